tile_shift_sequencer: RTL and testbench

TILE_SHIFT_SEQUENCER -- requirements
Module: tile_shift_sequencer

---
 rtl/tile_shift_sequencer_pkg.sv | 20 ++
 rtl/tile_shift_sequencer_fetch_fsm.sv | 109 ++++++++++
 rtl/tile_shift_sequencer.sv | 131 +++++++++++++
 tb/tb_tile_shift_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_shift_sequencer_pkg.sv
// Shared definitions for the tile shift sequencer.
//   fetch_state_e : fetch FSM states (IDLE, FETCH, READY)
//   SH_LOAD       : shifter phase value that means "load"
//   SH_PRE_LOAD   : phase immediately before a load
//   DEF_ADDR_W / DEF_STRIDE : default ROM address width and per-tile stride
package tile_shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } fetch_state_e;

  localparam logic [2:0] SH_LOAD     = 3'b111;
  localparam logic [2:0] SH_PRE_LOAD = SH_LOAD - 3'd1;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_STRIDE = 4;

endpackage

// File: rtl/tile_shift_sequencer_fetch_fsm.sv
// tile_fetch_fsm: ROM fetch state machine plus the one-tile staging buffer.
//
// Optional feature macro: TILE_SHIFT_FLIP_EN -- when defined, the hflip
// request is captured alongside each fetched tile; otherwise it is dropped
// and the staged flip bit is always 0.
//
// Ports:
//   clock, rst_n     : clock, internally synchronised active-low reset
//   line_start       : restart fetching at line_addr (wins over everything)
//   line_addr        : first tile address of the new line
//   hflip            : flip request captured with the acknowledged tile
//   rom_ack/rom_data : one-cycle ROM acknowledge with its data
//   load_evt         : shifter phase is moving 6->7 this cycle
//   rom_req/rom_addr : ROM request and its (stable) address
//   fetching         : FSM is in FETCH (a load now would underrun)
//   stage_vld        : staging buffer holds a tile (READY)
//   stage_data/flip  : staged tile bytes and flip bit
module tile_fetch_fsm
  import tile_shift_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic              hflip,
  input  logic              rom_ack,
  input  logic [31:0]       rom_data,
  input  logic              load_evt,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              fetching,
  output logic              stage_vld,
  output logic [31:0]       stage_data,
  output logic              stage_flip
);

`ifdef TILE_SHIFT_FLIP_EN
  localparam logic FLIP_ON = 1'b1;
`else
  localparam logic FLIP_ON = 1'b0;
`endif

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  // One-cycle gap after line_start: rom_req is held low so the ROM can see
  // the old request withdrawn before the new address is presented.
  logic              restart_gap, restart_gap_nxt;
  logic              ack_take;
  logic [31:0]       stage_data_p0;
  logic              stage_flip_p0;

  assign rom_req  = (state == FETCH) && !restart_gap;
  assign ack_take = rom_req && rom_ack && !line_start;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      restart_gap <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      restart_gap <= restart_gap_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    addr_nxt        = addr;
    restart_gap_nxt = 1'b0;
    if (line_start) begin
      state_nxt       = FETCH;
      addr_nxt        = line_addr;
      restart_gap_nxt = 1'b1;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        FETCH: begin
          if (ack_take) begin
            state_nxt = READY;
            addr_nxt  = addr + ADDR_W'(STRIDE);
          end
        end
        READY: begin
          if (load_evt) state_nxt = FETCH;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---- stage p0: tile staging (data path, no reset) ----
  always_ff @(posedge clock) begin
    if (ack_take) begin
      stage_data_p0 <= rom_data;
      stage_flip_p0 <= hflip & FLIP_ON;
    end
  end

  assign rom_addr   = addr;
  assign fetching   = (state == FETCH);
  assign stage_vld  = (state == READY);
  assign stage_data = stage_data_p0;
  assign stage_flip = stage_flip_p0;

endmodule

// File: rtl/tile_shift_sequencer.sv
// tile_shift_sequencer: drives a tile bitplane shifter. A 3-bit phase counter
// (sh) steps once per pixel; on each 6->7 step the staged tile is handed to
// the shifter, or zeros plus an underrun pulse if the fetch has not landed.
//
// Optional feature macro: TILE_SHIFT_FLIP_EN (see tile_fetch_fsm) makes
// flip_sel follow the per-tile hflip; without it flip_sel is always 0.
//
// Ports:
//   clock, reset_n     : system clock, asynchronous active-low reset
//   ce_pix             : pixel enable, one phase step per asserted cycle
//   line_start         : start a new line at line_addr
//   line_addr          : first tile address of the line
//   hflip              : horizontal flip request for the tile being fetched
//   rom_req, rom_addr  : ROM fetch request / address (held until rom_ack)
//   rom_ack, rom_data  : ROM acknowledge and data (byte_1 = [7:0])
//   sh                 : shifter phase, 3'b111 = load
//   byte_1..byte_4     : shifter load bytes
//   flip_sel           : use reversed shifter outputs for this tile
//   underrun           : one-cycle pulse when a load found no data
module tile_shift_sequencer
  import tile_shift_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic              hflip,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [31:0]       rom_data,
  output logic [2:0]        sh,
  output logic [7:0]        byte_1,
  output logic [7:0]        byte_2,
  output logic [7:0]        byte_3,
  output logic [7:0]        byte_4,
  output logic              flip_sel,
  output logic              underrun
);

  // Reset asserts asynchronously but is released only on a clock edge.
  logic rst_meta, rst_sync_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  logic [2:0]  phase;
  logic        load_evt;
  logic        fetching;
  logic        stage_vld;
  logic [31:0] stage_data;
  logic        stage_flip;
  logic [31:0] load_data_p1;
  logic        load_flip_p1;
  logic        underrun_p1;

  // line_start forces the phase, so it also suppresses a coincident load.
  assign load_evt = ce_pix && !line_start && (phase == SH_PRE_LOAD);

  always_ff @(posedge clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      phase <= 3'd0;
    end else if (line_start) begin
      phase <= SH_LOAD;
    end else if (ce_pix) begin
      phase <= phase + 3'd1;
    end
  end

  tile_fetch_fsm #(
    .ADDR_W (ADDR_W),
    .STRIDE (STRIDE)
  ) u_fetch (
    .clock      (clock),
    .rst_n      (rst_sync_n),
    .line_start (line_start),
    .line_addr  (line_addr),
    .hflip      (hflip),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .load_evt   (load_evt),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .fetching   (fetching),
    .stage_vld  (stage_vld),
    .stage_data (stage_data),
    .stage_flip (stage_flip)
  );

  // ---- stage p1: shifter load registers ----
  // Only written on the 6->7 step, so they hold steady throughout sh=7.
  always_ff @(posedge clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      load_data_p1 <= '0;
      load_flip_p1 <= 1'b0;
      underrun_p1  <= 1'b0;
    end else begin
      underrun_p1 <= 1'b0;
      if (load_evt) begin
        if (stage_vld) begin
          load_data_p1 <= stage_data;
          load_flip_p1 <= stage_flip;
        end else if (fetching) begin
          load_data_p1 <= '0;
          load_flip_p1 <= 1'b0;
          underrun_p1  <= 1'b1;
        end
      end
    end
  end

  assign sh       = phase;
  assign byte_1   = load_data_p1[7:0];
  assign byte_2   = load_data_p1[15:8];
  assign byte_3   = load_data_p1[23:16];
  assign byte_4   = load_data_p1[31:24];
  assign flip_sel = load_flip_p1;
  assign underrun = underrun_p1;

endmodule

// File: tb/tb_tile_shift_sequencer.sv
// Directed testbench for tile_shift_sequencer. A small ROM responder acks
// each request a programmable number of cycles after it rises; every tile
// load (sh 6->7) and every request address is checked against hand-computed
// expectation queues.
module tb_tile_shift_sequencer;

`ifdef TILE_SHIFT_FLIP_EN
  localparam bit FEXP = 1'b1;
`else
  localparam bit FEXP = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        ce_pix;
  logic        line_start;
  logic [19:0] line_addr;
  logic        hflip;
  logic        rom_req;
  logic [19:0] rom_addr;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic [2:0]  sh;
  logic [7:0]  byte_1, byte_2, byte_3, byte_4;
  logic        flip_sel;
  logic        underrun;

  tile_shift_sequencer #(.ADDR_W(20), .STRIDE(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ce_pix     (ce_pix),
    .line_start (line_start),
    .line_addr  (line_addr),
    .hflip      (hflip),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .sh         (sh),
    .byte_1     (byte_1),
    .byte_2     (byte_2),
    .byte_3     (byte_3),
    .byte_4     (byte_4),
    .flip_sel   (flip_sel),
    .underrun   (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    bit          flip;
    bit          und;
  } load_t;

  load_t       exp_loads[$];
  logic [19:0] exp_addrs[$];
  logic [19:0] cur_exp_addr;

  int   checks = 0;
  int   errors = 0;
  int   lat = 2;
  int   req_age = 0;
  bit   flip_drive = 1'b0;
  logic [2:0] prev_sh;
  logic       prev_req;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [19:0] a);
    if (a == 20'h03000) return 32'hA5C3_0F81;
    return {a[7:0] ^ 8'hC3, a[15:8] ^ 8'h5A, a[7:0] ^ 8'h1E, a[19:12]};
  endfunction

  task automatic exp_load(input logic [31:0] d, input bit f, input bit u);
    load_t e;
    e.data = d; e.flip = f; e.und = u;
    exp_loads.push_back(e);
  endtask

  task automatic observe(input bit ls_was);
    load_t e;
    if (!ls_was && prev_sh == 3'd6 && sh == 3'd7) begin
      chk("load_expected", 32'(exp_loads.size() > 0), 32'd1);
      if (exp_loads.size() > 0) begin
        e = exp_loads.pop_front();
        chk("load_bytes", {byte_4, byte_3, byte_2, byte_1}, e.data);
        chk("load_flip", 32'(flip_sel), 32'(e.flip));
        chk("load_underrun", 32'(underrun), 32'(e.und));
      end
    end else begin
      chk("underrun_quiet", 32'(underrun), 32'd0);
    end
    if (rom_req && !prev_req) begin
      chk("req_expected", 32'(exp_addrs.size() > 0), 32'd1);
      if (exp_addrs.size() > 0) begin
        cur_exp_addr = exp_addrs.pop_front();
        chk("req_addr", 32'(rom_addr), 32'(cur_exp_addr));
      end
    end else if (rom_req && prev_req) begin
      chk("addr_stable", 32'(rom_addr), 32'(cur_exp_addr));
    end
    prev_sh  = sh;
    prev_req = rom_req;
  endtask

  task automatic step(input bit ls, input logic [19:0] la, input bit stale);
    line_start = ls;
    line_addr  = la;
    if (rom_req) req_age++; else req_age = 0;
    rom_ack  = stale || (rom_req && req_age == lat + 1);
    rom_data = stale ? 32'hDEAD_BEEF : rom_word(rom_addr);
    hflip    = flip_drive && rom_addr[2];
    @(posedge clock);
    #1;
    line_start = 1'b0;
    rom_ack    = 1'b0;
    observe(ls);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 20'h0, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_sh"}, 32'(sh), 32'd0);
    chk({tag, "_req"}, 32'(rom_req), 32'd0);
    chk({tag, "_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_bytes"}, {byte_4, byte_3, byte_2, byte_1}, 32'd0);
    chk({tag, "_flip"}, 32'(flip_sel), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  task automatic end_scenario(input string tag);
    chk({tag, "_loads_left"}, 32'(exp_loads.size()), 32'd0);
    chk({tag, "_reqs_left"}, 32'(exp_addrs.size()), 32'd0);
    exp_loads.delete();
    exp_addrs.delete();
  endtask

  task automatic do_reset(input string tag);
    rom_ack = 1'b0;
    line_start = 1'b0;
    reset_n = 1'b0;
    #1;
    check_cleared(tag);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    prev_sh  = sh;
    prev_req = rom_req;
    req_age  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; ce_pix = 1'b0; line_start = 1'b0; line_addr = '0;
    hflip = 1'b0; rom_ack = 1'b0; rom_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check_cleared("reset");
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Idle: no line_start, a stray ack must not start anything.
    for (int i = 0; i < 100; i++) begin
      rom_ack  = (i == 50);
      rom_data = 32'h1234_5678;
      @(posedge clock);
      #1;
      rom_ack = 1'b0;
      chk("idle_req", 32'(rom_req), 32'd0);
    end
    check_cleared("idle");
    prev_sh = sh; prev_req = rom_req;

    // A: steady line, ack 2 cycles after each request.
    ce_pix = 1'b1; lat = 2;
    exp_addrs = '{20'h01000, 20'h01004, 20'h01008, 20'h0100C};
    exp_load(32'hC34A1E01, 1'b0, 1'b0);
    exp_load(32'hC74A1A01, 1'b0, 1'b0);
    exp_load(32'hCB4A1601, 1'b0, 1'b0);
    step(1'b1, 20'h01000, 1'b0);
    run(24);
    end_scenario("steady");
    do_reset("midline_reset");

    // B: ack withheld for 12 pixels -> underrun, late data on next load.
    lat = 12;
    exp_addrs = '{20'h03000, 20'h03004, 20'h03008};
    exp_load(32'h0000_0000, 1'b0, 1'b1);
    exp_load(32'hA5C3_0F81, 1'b0, 1'b0);
    exp_load(32'hC76A1A03, 1'b0, 1'b0);
    step(1'b1, 20'h03000, 1'b0);
    run(16);
    lat = 2;
    run(8);
    end_scenario("late_ack");
    do_reset("late_reset");

    // C: ack lands in the same cycle as the 6->7 step.
    lat = 6;
    exp_addrs = '{20'h06000, 20'h06004, 20'h06008};
    exp_load(32'h0000_0000, 1'b0, 1'b1);
    exp_load(32'hC33A1E06, 1'b0, 1'b0);
    exp_load(32'hC73A1A06, 1'b0, 1'b0);
    step(1'b1, 20'h06000, 1'b0);
    run(24);
    end_scenario("coincident");
    do_reset("coinc_reset");

    // D: hflip on alternate tiles.
    lat = 2; flip_drive = 1'b1;
    exp_addrs = '{20'h04000, 20'h04004, 20'h04008, 20'h0400C};
    exp_load(32'hC31A1E04, 1'b0, 1'b0);
    exp_load(32'hC71A1A04, FEXP, 1'b0);
    exp_load(32'hCB1A1604, 1'b0, 1'b0);
    step(1'b1, 20'h04000, 1'b0);
    run(24);
    flip_drive = 1'b0;
    end_scenario("hflip");
    do_reset("flip_reset");

    // E: line_start while a request is outstanding, then a stale ack.
    lat = 20;
    exp_addrs = '{20'h05000, 20'h20000, 20'h20004};
    exp_load(32'hC35A1E20, 1'b0, 1'b0);
    step(1'b1, 20'h05000, 1'b0);
    run(4);
    step(1'b1, 20'h20000, 1'b0);
    chk("restart_gap_req", 32'(rom_req), 32'd0);
    lat = 2;
    step(1'b0, 20'h0, 1'b1);
    chk("rerequest_req", 32'(rom_req), 32'd1);
    chk("rerequest_addr", 32'(rom_addr), 32'h20000);
    run(7);
    end_scenario("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
